// File: rtl/mac_vlg_pkg.sv
// -----------------------------------------------------------------------------
// mac_vlg_pkg
// Shared types for the MAC TX path: address/ethertype aliases, the per-requester
// frame header carried alongside rts, and the transmit-arbiter state encoding.
// -----------------------------------------------------------------------------
package mac_vlg_pkg;

  typedef logic [47:0] mac_addr_t;
  typedef logic [15:0] ethertype_t;

  // Header presented by each requester while rts is high: destination MAC in
  // the upper 48 bits, ethertype in the lower 16 bits.
  typedef struct packed {
    mac_addr_t  dst;
    ethertype_t ethertype;
  } hdr_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    GRANT = 3'd1,
    WAIT  = 3'd2,
    DATA  = 3'd3,
    GAP   = 3'd4
  } tx_arb_fsm_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/eth_vlg_rr_sel.sv
// -----------------------------------------------------------------------------
// eth_vlg_rr_sel
// Combinational round-robin selector. Starting at index ptr+1 (mod N) and
// walking upward, the first asserted request wins.
//
// Ports
//   req     in  N   request vector
//   ptr     in  PW  index of the previous winner
//   onehot  out N   one-hot winner (all zero when no request)
//   idx     out PW  binary winner index (equals ptr when no request)
// -----------------------------------------------------------------------------
module eth_vlg_rr_sel #(
  parameter int N  = 4,
  parameter int PW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  onehot,
  output logic [PW-1:0] idx
);

  // Walk the search distances from farthest to nearest; a later hit overwrites
  // an earlier one, so the nearest requester after ptr is what remains.
  always_comb begin
    onehot = '0;
    idx    = ptr;
    for (int k = N; k >= 1; k--) begin
      int          c;
      logic [N-1:0] cand;
      c    = (int'(ptr) + k) % N;
      cand = N'(1) << c;
      if (|(req & cand)) begin
        onehot = cand;
        idx    = PW'(c);
      end
    end
  end

endmodule

// File: rtl/eth_vlg_tx_arb.sv
// -----------------------------------------------------------------------------
// eth_vlg_tx_arb
// Transmit arbiter in front of the Ethernet MAC. N protocol engines (ARP, ICMP,
// UDP, TCP, ...) raise rts with a header; when the MAC is ready one of them is
// granted round-robin with a single-cycle acc pulse, its header is latched onto
// mac_dst/mac_type, and its byte stream is forwarded to the MAC with one cycle
// of latency. After each frame (or an abandoned grant) an inter-frame gap of
// IFG cycles is enforced before the next grant.
//
// Ports
//   clk       in   1       clock, rising edge
//   rst_n     in   1       asynchronous active-low reset
//   rts       in   N       per-requester ready-to-send (level)
//   hdr       in   N x 64  per-requester {dst, ethertype}, stable while rts
//   dat       in   N x 8   per-requester frame byte
//   val       in   N       per-requester byte valid (one contiguous run/frame)
//   acc       out  N       one-hot grant pulse
//   mac_rdy   in   1       MAC able to start a frame
//   mac_dat   out  8       forwarded byte
//   mac_val   out  1       forwarded byte valid
//   mac_dst   out  48      destination MAC latched at grant
//   mac_type  out  16      ethertype latched at grant
//   busy      out  1       arbiter not in IDLE
// -----------------------------------------------------------------------------
module eth_vlg_tx_arb
  import mac_vlg_pkg::*;
#(
  parameter int N       = 4,
  parameter int IFG     = 12,
  parameter int TIMEOUT = 64
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N-1:0]        rts,
  input  hdr_t [N-1:0]        hdr,
  input  logic [N-1:0][7:0]   dat,
  input  logic [N-1:0]        val,
  output logic [N-1:0]        acc,
  input  logic                mac_rdy,
  output logic [7:0]          mac_dat,
  output logic                mac_val,
  output mac_addr_t           mac_dst,
  output ethertype_t          mac_type,
  output logic                busy
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;
  // Wide enough to hold the larger of the two limits, so neither the gap nor
  // the timeout count can wrap while a state is being timed.
  localparam int CW = $clog2(max_int(IFG, TIMEOUT) + 1);

  tx_arb_fsm_t   state_q, state_d;
  logic [PW-1:0] ptr_q, ptr_d;
  logic [PW-1:0] win_q, win_d;
  logic [N-1:0]  acc_q, acc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    mac_dat_q, mac_dat_d;
  logic          mac_val_q, mac_val_d;
  mac_addr_t     dst_q, dst_d;
  ethertype_t    type_q, type_d;

  logic [N-1:0]  sel_onehot;
  logic [PW-1:0] sel_idx;
  logic          win_val;
  logic [7:0]    win_dat;

  eth_vlg_rr_sel #(
    .N  (N),
    .PW (PW)
  ) u_rr_sel (
    .req    (rts),
    .ptr    (ptr_q),
    .onehot (sel_onehot),
    .idx    (sel_idx)
  );

  // Only the granted requester's stream is looked at; val from everyone else
  // is ignored for the whole grant.
  assign win_val = val[win_q];
  assign win_dat = dat[win_q];

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    win_d     = win_q;
    acc_d     = '0;
    cnt_d     = cnt_q;
    mac_dat_d = mac_dat_q;
    mac_val_d = 1'b0;
    dst_d     = dst_q;
    type_d    = type_q;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        // A requester that dropped rts is simply absent from the search.
        if (|rts && mac_rdy) begin
          acc_d   = sel_onehot;
          win_d   = sel_idx;
          ptr_d   = sel_idx;
          dst_d   = hdr[sel_idx].dst;
          type_d  = hdr[sel_idx].ethertype;
          state_d = GRANT;
        end
      end

      GRANT: begin
        cnt_d   = '0;
        state_d = WAIT;
      end

      WAIT: begin
        if (win_val) begin
          mac_val_d = 1'b1;
          mac_dat_d = win_dat;
          state_d   = DATA;
        end else if (int'(cnt_q) + 1 >= TIMEOUT) begin
          // Requester never started: give the slot up without emitting bytes.
          cnt_d   = '0;
          state_d = GAP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      DATA: begin
        if (win_val) begin
          mac_val_d = 1'b1;
          mac_dat_d = win_dat;
        end else begin
          // mac_val falls on this same edge, so the gap count starts at the
          // first idle cycle seen by the MAC.
          cnt_d   = '0;
          state_d = GAP;
        end
      end

      GAP: begin
        if (int'(cnt_q) + 1 >= IFG) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  // Everything, including the byte path, is cleared asynchronously so that a
  // reset in the middle of a frame takes mac_val down immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ptr_q     <= PW'(N - 1);
      win_q     <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      mac_dat_q <= '0;
      mac_val_q <= 1'b0;
      dst_q     <= '0;
      type_q    <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      win_q     <= win_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      mac_dat_q <= mac_dat_d;
      mac_val_q <= mac_val_d;
      dst_q     <= dst_d;
      type_q    <= type_d;
    end
  end

  assign acc      = acc_q;
  assign mac_dat  = mac_dat_q;
  assign mac_val  = mac_val_q;
  assign mac_dst  = dst_q;
  assign mac_type = type_q;
  assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_eth_vlg_tx_arb.sv
// -----------------------------------------------------------------------------
// tb_eth_vlg_tx_arb
// Behavioural requesters drive frames; every byte they put on the wire while
// granted is pushed to a scoreboard queue. A negedge monitor pops and compares
// forwarded bytes, and checks each grant against a round-robin reference
// computed from the request vector seen on the previous cycle.
// -----------------------------------------------------------------------------
module tb_eth_vlg_tx_arb;
  import mac_vlg_pkg::*;

  localparam int N       = 4;
  localparam int IFG     = 12;
  localparam int TIMEOUT = 64;

  localparam int M_IDLE = 0;
  localparam int M_REQ  = 1;
  localparam int M_GNT  = 2;
  localparam int M_SEND = 3;
  localparam int M_DONE = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [N-1:0]      rts;
  hdr_t [N-1:0]      hdr;
  logic [N-1:0][7:0] dat;
  logic [N-1:0]      val;
  logic [N-1:0]      acc;
  logic              mac_rdy;
  logic [7:0]        mac_dat;
  logic              mac_val;
  mac_addr_t         mac_dst;
  ethertype_t        mac_type;
  logic              busy;

  always #5 clk = ~clk;

  eth_vlg_tx_arb #(.N(N), .IFG(IFG), .TIMEOUT(TIMEOUT)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rts      (rts),
    .hdr      (hdr),
    .dat      (dat),
    .val      (val),
    .acc      (acc),
    .mac_rdy  (mac_rdy),
    .mac_dat  (mac_dat),
    .mac_val  (mac_val),
    .mac_dst  (mac_dst),
    .mac_type (mac_type),
    .busy     (busy)
  );

  typedef struct {
    int         src;
    logic [7:0] b;
  } byte_t;

  byte_t      exp_q[$];
  int         grant_log[$];
  int         grant_cyc[$];
  int         errors = 0;
  int         checks = 0;
  int         cyc = 0;
  int         mode[N];
  int         len_m[N];
  int         sent[N];
  logic [7:0] base_m[N];
  hdr_t       hdr_m[N];
  int         acc_cnt[N];
  int         drv_last;
  int         popped;
  int         rand_left;
  bit         noise_en, rnd_drop, rnd_rdy;
  int         exp_order[5] = '{0, 1, 2, 3, 0};

  // monitor state
  logic [N-1:0] prev_rts;
  logic         prev_rdy, prev_mval;
  int           last_win, idle_cnt, last_acc_cyc;
  bit           have_frame, have_acc, last_tmo;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Round-robin rule: first requester found walking up from last winner + 1.
  function automatic int rr_ref(input logic [N-1:0] r, input int last);
    for (int k = 1; k <= N; k++) begin
      int i;
      i = (last + k) % N;
      if (r[i]) return i;
    end
    return -1;
  endfunction

  function automatic bit all_idle();
    for (int i = 0; i < N; i++) if (mode[i] != M_IDLE) return 0;
    return 1;
  endfunction

  always @(negedge clk) begin : monitor
    int          e;
    logic [N-1:0] ew;
    byte_t       x;
    if (!rst_n) begin
      last_win   = N - 1;
      have_frame = 0;
      have_acc   = 0;
      last_tmo   = 0;
      prev_mval  = 0;
      prev_rts   = '0;
      prev_rdy   = 0;
      idle_cnt   = 0;
    end else begin
      if (acc != '0) begin
        e  = rr_ref(prev_rts, last_win);
        ew = (e >= 0) ? (N'(1) << e) : '0;
        check("acc_winner", acc, ew);
        check("acc_mac_rdy", prev_rdy, 1);
        check("busy_at_acc", busy, 1);
        if (e >= 0) begin
          check("acc_dst", mac_dst, hdr_m[e].dst);
          check("acc_type", mac_type, hdr_m[e].ethertype);
          if (have_acc && last_tmo)
            check("tmo_spacing", (cyc - last_acc_cyc) >= TIMEOUT + IFG + 2, 1);
          last_win = e;
          acc_cnt[e]++;
          grant_log.push_back(e);
          grant_cyc.push_back(cyc);
          last_tmo     = (len_m[e] == 0);
          last_acc_cyc = cyc;
          have_acc     = 1;
        end
      end
      if (mac_val) begin
        if (!prev_mval && have_frame)
          check("ifg_idle", idle_cnt >= IFG + 3, 1);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_byte: got %0h expected no byte (t=%0t)", mac_dat, $time);
        end else begin
          x = exp_q.pop_front();
          popped++;
          check("byte", mac_dat, x.b);
          check("byte_src", last_win, x.src);
          check("dst_hold", mac_dst, hdr_m[x.src].dst);
          check("busy_in_frame", busy, 1);
        end
        idle_cnt   = 0;
        have_frame = 1;
      end else begin
        idle_cnt++;
      end
      prev_mval = mac_val;
      prev_rts  = rts;
      prev_rdy  = mac_rdy;
    end
  end

  // One cycle of requester behaviour, called just after each rising edge.
  task automatic drive_cycle();
    for (int i = 0; i < N; i++) begin
      val[i] = 1'b0;
      case (mode[i])
        M_REQ: begin
          if (acc[i]) begin
            rts[i]   = 1'b0;
            mode[i]  = M_GNT;
            drv_last = i;
          end else if (rnd_drop && $urandom_range(0, 40) == 0) begin
            rts[i]  = 1'b0;
            mode[i] = M_IDLE;
          end
        end
        M_GNT: begin
          if (len_m[i] == 0) mode[i] = M_DONE;
          else begin
            mode[i] = M_SEND;
            sent[i] = 0;
          end
        end
        M_DONE: mode[i] = M_IDLE;
        default: ;
      endcase
      if (mode[i] == M_SEND) begin
        if (sent[i] < len_m[i]) begin
          val[i] = 1'b1;
          dat[i] = base_m[i] + 8'(sent[i]);
          exp_q.push_back('{src: i, b: dat[i]});
          sent[i]++;
        end else begin
          mode[i] = M_DONE;
        end
      end
      if (mode[i] == M_IDLE && i != drv_last && noise_en) begin
        val[i] = 1'($urandom);
        dat[i] = 8'($urandom);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    drive_cycle();
  endtask

  task automatic raise(input int i, input int l, input logic [7:0] b, input hdr_t h);
    hdr_m[i]  = h;
    hdr[i]    = h;
    len_m[i]  = l;
    base_m[i] = b;
    sent[i]   = 0;
    mode[i]   = M_REQ;
    rts[i]    = 1'b1;
    val[i]    = 1'b0;
  endtask

  task automatic wait_quiet(input int budget, input string name);
    int n;
    n = 0;
    while (!(all_idle() && !busy && exp_q.size() == 0) && n < budget) begin
      tick();
      n++;
    end
    check({name, "_done"}, n < budget, 1);
  endtask

  task automatic rand_raise();
    hdr_t h;
    for (int i = 0; i < N; i++) begin
      if (mode[i] == M_IDLE && rand_left > 0 && $urandom_range(0, 7) == 0) begin
        h.dst       = {16'($urandom), 32'($urandom)};
        h.ethertype = 16'($urandom);
        raise(i, ($urandom_range(0, 11) == 0) ? 0 : int'($urandom_range(1, 12)), 8'($urandom), h);
        rand_left--;
      end
    end
  endtask

  initial begin
    int n, g0, gsz, c0, a0, p0;
    rst_n = 1'b0; rts = '0; val = '0; dat = '0; hdr = '0; mac_rdy = 1'b0;
    noise_en = 0; rnd_drop = 0; rnd_rdy = 0; drv_last = -1; popped = 0;
    for (int i = 0; i < N; i++) begin
      mode[i] = M_IDLE; len_m[i] = 0; sent[i] = 0; acc_cnt[i] = 0; base_m[i] = '0; hdr_m[i] = '0;
    end
    repeat (3) tick();
    check("rst_acc", acc, 0);
    check("rst_mac_val", mac_val, 0);
    check("rst_mac_dat", mac_dat, 0);
    check("rst_mac_dst", mac_dst, 0);
    check("rst_mac_type", mac_type, 0);
    check("rst_busy", busy, 0);
    rst_n = 1'b1;
    mac_rdy = 1'b1;
    tick();

    // All four requesting at once, requester 0 asking again after its frame.
    grant_log.delete();
    for (int i = 0; i < N; i++)
      raise(i, 4, 8'(i * 16), '{dst: 48'h0A00_0000_0000 + 48'(i), ethertype: 16'h0800 + 16'(i)});
    n = 0;
    while (!(grant_log.size() >= 1 && mode[0] == M_IDLE) && n < 500) begin tick(); n++; end
    check("rr_first_done", n < 500, 1);
    raise(0, 4, 8'h40, '{dst: 48'h0A00_0000_0010, ethertype: 16'h0806});
    wait_quiet(2000, "rr");
    check("rr_count", grant_log.size(), 5);
    for (int k = 0; k < 5; k++)
      if (k < grant_log.size()) check($sformatf("rr_order%0d", k), grant_log[k], exp_order[k]);

    // Single 10-byte frame from requester 2, others chattering on val.
    noise_en = 1;
    a0 = acc_cnt[2];
    p0 = popped;
    raise(2, 10, 8'h00, '{dst: 48'h0200_0000_0001, ethertype: 16'h0800});
    wait_quiet(500, "single");
    check("single_acc_cnt", acc_cnt[2] - a0, 1);
    check("single_bytes", popped - p0, 10);
    check("single_type", mac_type, 16'h0800);
    check("single_dst", mac_dst, 48'h0200_0000_0001);

    // Requester 1 never sends; requester 2 waits behind it.
    g0 = grant_log.size();
    raise(1, 0, 8'h00, '{dst: 48'h0200_0000_0011, ethertype: 16'h86DD});
    n = 0;
    while (grant_log.size() == g0 && n < 50) begin tick(); n++; end
    check("tmo_granted", n < 50, 1);
    raise(2, 3, 8'h80, '{dst: 48'h0200_0000_0022, ethertype: 16'h0800});
    wait_quiet(500, "tmo");
    gsz = grant_log.size();
    check("tmo_grants", gsz - g0, 2);
    if (gsz >= 2) begin
      check("tmo_next_req", grant_log[gsz-1], 2);
      check("tmo_delay", grant_cyc[gsz-1] - grant_cyc[gsz-2], TIMEOUT + IFG + 2);
    end

    // MAC not ready: requester 1 must wait, then be granted on the next cycle.
    mac_rdy = 1'b0;
    a0 = acc_cnt[1];
    raise(1, 5, 8'h20, '{dst: 48'h0200_0000_0033, ethertype: 16'h0800});
    repeat (20) tick();
    check("rdy_low_no_acc", acc_cnt[1] - a0, 0);
    mac_rdy = 1'b1;
    c0 = cyc;
    wait_quiet(500, "rdy");
    check("rdy_acc_cnt", acc_cnt[1] - a0, 1);
    gsz = grant_cyc.size();
    if (gsz >= 1) check("rdy_acc_latency", grant_cyc[gsz-1] - c0, 1);

    // Reset in the middle of a 10-byte frame.
    raise(0, 10, 8'h50, '{dst: 48'h0200_0000_0044, ethertype: 16'h0800});
    n = 0;
    while (!(mode[0] == M_SEND && sent[0] == 5) && n < 200) begin tick(); n++; end
    check("rst_mid_reached", n < 200, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_mid_mac_val", mac_val, 0);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_acc", acc, 0);
    check("rst_mid_dst", mac_dst, 0);
    exp_q.delete();
    for (int i = 0; i < N; i++) mode[i] = M_IDLE;
    rts = '0; val = '0; drv_last = -1;
    tick();
    tick();
    rst_n = 1'b1;
    a0 = acc_cnt[3];
    raise(3, 6, 8'hA0, '{dst: 48'h0200_0000_0055, ethertype: 16'h0806});
    wait_quiet(500, "post_rst");
    check("post_rst_acc3", acc_cnt[3] - a0, 1);
    gsz = grant_log.size();
    if (gsz >= 1) check("post_rst_winner", grant_log[gsz-1], 3);

    // Randomized traffic with dropped requests and a stalling MAC.
    rnd_drop = 1;
    rnd_rdy = 1;
    rand_left = 40;
    n = 0;
    while ((rand_left > 0 || !all_idle() || busy || exp_q.size() != 0) && n < 20000) begin
      tick();
      if (rnd_rdy) mac_rdy = ($urandom_range(0, 3) != 0);
      rand_raise();
      n++;
    end
    check("rand_done", n < 20000, 1);
    check("rand_queue_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/eth_vlg_tx_arb.md
ETH_VLG_TX_ARB -- requirements
Module: eth_vlg_tx_arb

Interface
REQ-001 SHALL have parameter N, default 4, number of frame requesters (ARP, ICMP, UDP, TCP); legal range 2..8.
REQ-002 SHALL have parameter IFG, default 12, idle cycles enforced between granted frames.
REQ-003 SHALL have parameter TIMEOUT, default 64, cycles a grant may wait for first byte.
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 rts  in  N  per-requester ready-to-send, level, held until acc seen.
REQ-007 hdr  in  N x 64  per-requester {mac_addr_t dst, ethertype_t type}, stable while rts high.
REQ-008 dat  in  N x 8  per-requester frame byte.
REQ-009 val  in  N  per-requester byte valid; contiguous run = one frame; fall = end of frame.
REQ-010 acc  out  N  one-hot grant pulse, one cycle.
REQ-011 mac_rdy  in  1  MAC TX idle and able to start frame.
REQ-012 mac_dat  out  8  muxed byte.
REQ-013 mac_val  out  1  muxed byte valid.
REQ-014 mac_dst  out  48  latched destination MAC.
REQ-015 mac_type  out  16  latched ethertype.
REQ-016 busy  out  1  high in any state except IDLE.

Function
REQ-017 FSM states: IDLE, GRANT, WAIT, DATA, GAP.
REQ-018 IDLE: when any rts high and mac_rdy high, select winner, pulse acc[winner], latch hdr[winner] into mac_dst/mac_type, go GRANT.
REQ-019 Winner: round-robin; search starts at index ptr+1 mod N; ptr updated to winner on grant; ptr resets to N-1 (index 0 first).
REQ-020 GRANT lasts one cycle, then WAIT.
REQ-021 WAIT: val[winner] high -> DATA; timeout counter reaching TIMEOUT -> GAP without output.
REQ-022 DATA: mac_dat/mac_val = registered dat/val of winner, one-cycle latency; val of non-winners ignored.
REQ-023 DATA: val[winner] low -> GAP; mac_val low on following cycle.
REQ-024 GAP: counter counts IFG cycles from mac_val deassertion, then IDLE; no acc during GAP.
REQ-025 acc never asserted while mac_rdy low; rts dropped before grant is simply not served.
REQ-026 Simultaneous rts from all N: grants issued in strict rotation, each requester served once per N frames.
REQ-027 rts of current winner still high after frame = new request, competes normally (no back-to-back starvation of others).
REQ-028 Counters sized $clog2(max(IFG,TIMEOUT)+1); no wrap within a state.
REQ-029 mac_dst/mac_type held from grant until next grant.

Reset
REQ-030 rst_n low: state IDLE, acc 0, mac_val 0, mac_dat 0, mac_dst 0, mac_type 0, busy 0, counters 0, ptr N-1.
REQ-031 Reset mid-frame: mac_val drops asynchronously; frame abandoned; after release arbitration restarts at index 0.

Structure
REQ-032 State enum tx_arb_fsm_t and hdr struct {mac_addr_t, ethertype_t} SHALL live in mac_vlg_pkg.
REQ-033 Round-robin selector SHALL be sub-module eth_vlg_rr_sel (combinational, inputs req and ptr, outputs one-hot and index).

Verification
REQ-034 Single: rts[2]=1, hdr dst 02:00:00:00:00:01 type 0x0800, 10 bytes 0x00..0x09 -> acc[2] one pulse, mac_dat 0x00..0x09 contiguous, mac_type 0x0800.
REQ-035 All four rts high, each sends 4 bytes -> grant order 0,1,2,3, then 0 again; ≥12 idle cycles between frames.
REQ-036 Granted requester never asserts val -> after 64 cycles FSM enters GAP, then next requester granted.
REQ-037 mac_rdy low with rts[1] high for 20 cycles -> no acc; mac_rdy high -> acc[1] next cycle.
REQ-038 rst_n low at byte 5 of 10-byte frame -> mac_val 0 immediately, busy 0; after release rts[3] granted normally.
